instr_queue_mw: RTL and testbench

- Next-generation instruction queue: entry-granular circular FIFO between fetch and dispatch.
- Accepts a variable number of instructions per cycle (0..PUSH_W) and releases a variable number of the oldest entries per cycle (0..POP_W).
- No line-granular gaps: occupancy is tracked per entry.
- Adds flush (branch mispredict / exception recovery) and exposes occupancy/free counts to fetch and dispatch.

---
 rtl/instr_queue_mw.sv | 159 +++++++++++++++
 tb/tb_instr_queue_mw.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue_mw.sv
// ---------------------------------------------------------------------------
// instr_queue_mw
//   Entry-granular circular instruction queue between fetch and dispatch.
//   Each cycle it accepts 0..PUSH_W instructions and releases 0..POP_W of the
//   oldest entries. Flush discards all entries.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 discard all entries (wins over push and pop)
//   push_valid/push_cnt   push request, lanes 0..push_cnt-1 of push_instr
//   push_instr            lane i at [i*IW +: IW]
//   push_order            order tag of lane 0; lane i gets push_order+i
//   push_ready            at least PUSH_W free slots (registered count)
//   pop_cnt               number of oldest entries consumed this cycle
//   out_valid/instr/order i-th oldest entry, out_valid[i] = (count > i)
//   count, free_cnt       occupancy and DEPTH - occupancy
//   err                   sticky protocol error
//
// Build option:
//   IQ_PROTOCOL_CHECK_EN  when defined, err flags protocol violations and
//                         matching assertions are compiled in; otherwise err
//                         is tied to 0. Clamping behaviour is identical.
// ---------------------------------------------------------------------------
module instr_queue_mw #(
  parameter int DEPTH  = 16,
  parameter int PUSH_W = 2,
  parameter int POP_W  = 2,
  parameter int IW     = 32,
  parameter int OW     = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1,
  localparam int PCW   = $clog2(PUSH_W + 1),
  localparam int QCW   = $clog2(POP_W + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push_valid,
  input  logic [PCW-1:0]      push_cnt,
  input  logic [PUSH_W*IW-1:0] push_instr,
  input  logic [OW-1:0]       push_order,
  output logic                push_ready,
  input  logic [QCW-1:0]      pop_cnt,
  output logic [POP_W-1:0]    out_valid,
  output logic [POP_W*IW-1:0] out_instr,
  output logic [POP_W*OW-1:0] out_order,
  output logic [CW-1:0]       count,
  output logic [CW-1:0]       free_cnt,
  output logic                err
);

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_instr_mem [DEPTH];
  logic [OW-1:0] r_order_mem [DEPTH];

  logic [CW-1:0] w_free;
  logic [CW-1:0] w_push_lanes;
  logic [CW-1:0] w_push_n;
  logic [CW-1:0] w_pop_req;
  logic [CW-1:0] w_pop_n;
  logic          w_push_acc;
  logic [AW-1:0] w_wr_idx [PUSH_W];
  logic [AW-1:0] w_rd_idx [POP_W];

  assign w_free     = CW'(DEPTH) - r_count;
  assign push_ready = (w_free >= CW'(PUSH_W));
  assign w_push_acc = push_valid & push_ready & ~flush;

  // Oversized push/pop requests are clamped to the lane count; pops are
  // further limited to what is currently stored.
  always_comb begin
    w_push_lanes = CW'(push_cnt);
    if (CW'(push_cnt) > CW'(PUSH_W))
      w_push_lanes = CW'(PUSH_W);
    w_push_n = w_push_acc ? w_push_lanes : '0;

    w_pop_req = CW'(pop_cnt);
    if (CW'(pop_cnt) > CW'(POP_W))
      w_pop_req = CW'(POP_W);
    w_pop_n = (w_pop_req > r_count) ? r_count : w_pop_req;
  end

  // Lane indices wrap naturally through the AW-bit add.
  always_comb begin
    for (int unsigned i = 0; i < PUSH_W; i++)
      w_wr_idx[i] = r_wr_ptr + AW'(i);
    for (int unsigned i = 0; i < POP_W; i++)
      w_rd_idx[i] = r_rd_ptr + AW'(i);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + AW'(w_pop_n);
      r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
      r_count  <= r_count + w_push_n - w_pop_n;
    end
  end

  // Storage carries no reset; only lanes below the accepted count write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < PUSH_W; i++) begin
        if (CW'(i) < w_push_n) begin
          r_instr_mem[w_wr_idx[i]] <= push_instr[i*IW +: IW];
          r_order_mem[w_wr_idx[i]] <= push_order + OW'(i);
        end
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_instr = '0;
    out_order = '0;
    for (int unsigned i = 0; i < POP_W; i++) begin
      out_valid[i]           = (r_count > CW'(i));
      out_instr[i*IW +: IW]  = r_instr_mem[w_rd_idx[i]];
      out_order[i*OW +: OW]  = r_order_mem[w_rd_idx[i]];
    end
  end

  assign count    = r_count;
  assign free_cnt = w_free;

`ifdef IQ_PROTOCOL_CHECK_EN
  logic r_err;
  logic w_push_stall_viol;
  logic w_pop_over_viol;
  logic w_push_wide_viol;

  assign w_push_stall_viol = push_valid & ~push_ready & ~flush;
  assign w_pop_over_viol   = (CW'(pop_cnt) > r_count);
  assign w_push_wide_viol  = (CW'(push_cnt) > CW'(PUSH_W));

  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_push_stall_viol | w_pop_over_viol | w_push_wide_viol)
      r_err <= 1'b1;
  end

  assign err = r_err;

`ifndef SYNTHESIS
  a_push_when_not_ready: assert property (@(posedge clk) disable iff (rst) !w_push_stall_viol);
  a_pop_beyond_count:    assert property (@(posedge clk) disable iff (rst) !w_pop_over_viol);
  a_push_cnt_too_wide:   assert property (@(posedge clk) disable iff (rst) !w_push_wide_viol);
`endif
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_queue_mw.sv
// ---------------------------------------------------------------------------
// tb_instr_queue_mw
//   Self-checking bench for instr_queue_mw (DEPTH=8, PUSH_W=2, POP_W=2).
//   A queue of {instr, order} entries models the FIFO; outputs are compared
//   one time unit after every rising edge.
// ---------------------------------------------------------------------------
module tb_instr_queue_mw;

  localparam int DEPTH  = 8;
  localparam int PUSH_W = 2;
  localparam int POP_W  = 2;
  localparam int IW     = 32;
  localparam int OW     = 64;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int PCW    = $clog2(PUSH_W + 1);
  localparam int QCW    = $clog2(POP_W + 1);

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic                 push_valid;
  logic [PCW-1:0]       push_cnt;
  logic [PUSH_W*IW-1:0] push_instr;
  logic [OW-1:0]        push_order;
  logic                 push_ready;
  logic [QCW-1:0]       pop_cnt;
  logic [POP_W-1:0]     out_valid;
  logic [POP_W*IW-1:0]  out_instr;
  logic [POP_W*OW-1:0]  out_order;
  logic [CW-1:0]        count;
  logic [CW-1:0]        free_cnt;
  logic                 err;

  instr_queue_mw #(
    .DEPTH (DEPTH),
    .PUSH_W(PUSH_W),
    .POP_W (POP_W),
    .IW    (IW),
    .OW    (OW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push_valid(push_valid),
    .push_cnt  (push_cnt),
    .push_instr(push_instr),
    .push_order(push_order),
    .push_ready(push_ready),
    .pop_cnt   (pop_cnt),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_order (out_order),
    .count     (count),
    .free_cnt  (free_cnt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] instr;
    logic [OW-1:0] ord;
  } ent_t;

  ent_t        mq[$];
  bit          m_err;
  int          n_checks;
  int          n_errors;
  logic [OW-1:0] order_ctr;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    int sz;
    logic [POP_W-1:0] exp_valid;
    sz = mq.size();
    check_eq("count", 128'(count), 128'(sz));
    check_eq("free_cnt", 128'(free_cnt), 128'(DEPTH - sz));
    check_eq("push_ready", 128'(push_ready), 128'((DEPTH - sz) >= PUSH_W));
    for (int i = 0; i < POP_W; i++) exp_valid[i] = (sz > i);
    check_eq("out_valid", 128'(out_valid), 128'(exp_valid));
    for (int i = 0; i < POP_W; i++) begin
      if (i < sz) begin
        check_eq($sformatf("out_instr[%0d]", i), 128'(out_instr[i*IW +: IW]), 128'(mq[i].instr));
        check_eq($sformatf("out_order[%0d]", i), 128'(out_order[i*OW +: OW]), 128'(mq[i].ord));
      end
    end
    check_eq("err", 128'(err), 128'(m_err));
  endtask

  // Advance the model by one cycle from the currently driven inputs, clock
  // the DUT, then compare.
  task automatic step();
    int  sz;
    int  lanes;
    int  pops;
    bit  rdy;
    ent_t e;
    sz  = mq.size();
    rdy = ((DEPTH - sz) >= PUSH_W);
    if (rst) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
`ifdef IQ_PROTOCOL_CHECK_EN
      if ((push_valid && !rdy && !flush) || (int'(pop_cnt) > sz) || (int'(push_cnt) > PUSH_W))
        m_err = 1'b1;
`endif
      if (flush) begin
        mq.delete();
      end else begin
        pops = int'(pop_cnt);
        if (pops > POP_W) pops = POP_W;
        if (pops > sz)    pops = sz;
        repeat (pops) void'(mq.pop_front());
        lanes = int'(push_cnt);
        if (lanes > PUSH_W) lanes = PUSH_W;
        if (push_valid && rdy) begin
          for (int l = 0; l < lanes; l++) begin
            e.instr = push_instr[l*IW +: IW];
            e.ord   = push_order + OW'(l);
            mq.push_back(e);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit pv, input int pc, input int pp, input bit fl);
    push_valid = pv;
    push_cnt   = PCW'(pc);
    pop_cnt    = QCW'(pp);
    flush      = fl;
    push_instr = {$urandom(), $urandom()};
    push_order = order_ctr;
    if (pv) order_ctr = order_ctr + OW'(pc);
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    m_err      = 1'b0;
    order_ctr  = 64'd100;
    rst        = 1'b1;
    idle();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Two-lane push with known contents and order tag.
    drive(1'b1, 2, 0, 1'b0);
    push_instr = {32'hBBBB_0002, 32'hAAAA_0001};
    push_order = 64'd10;
    step();
    check_eq("tp1_instr", 128'(out_instr), 128'({32'hBBBB_0002, 32'hAAAA_0001}));
    check_eq("tp1_order0", 128'(out_order[63:0]), 128'(64'd10));
    check_eq("tp1_order1", 128'(out_order[127:64]), 128'(64'd11));

    // From empty: push one while popping one; pop must be ignored.
    drive(1'b0, 0, 0, 1'b1); step();
    drive(1'b1, 1, 1, 1'b0); step();
    check_eq("push_pop_empty_count", 128'(count), 128'(1));

    // Fill to 7, then push while not ready.
    drive(1'b0, 0, 0, 1'b1); step();
    drive(1'b1, 2, 0, 1'b0); step();
    drive(1'b1, 2, 0, 1'b0); step();
    drive(1'b1, 2, 0, 1'b0); step();
    drive(1'b1, 1, 0, 1'b0); step();
    check_eq("fill7_ready", 128'(push_ready), 128'(0));
    drive(1'b1, 1, 0, 1'b0); step();
    check_eq("fill7_hold", 128'(count), 128'(7));

    // Count 5, then flush together with push and pop.
    drive(1'b0, 0, 0, 1'b1); step();
    drive(1'b1, 2, 0, 1'b0); step();
    drive(1'b1, 2, 0, 1'b0); step();
    drive(1'b1, 1, 0, 1'b0); step();
    drive(1'b1, 2, 2, 1'b1); step();
    check_eq("flush_count", 128'(count), 128'(0));
    drive(1'b1, 2, 0, 1'b0); step();

    // Over-pop from a single entry.
    drive(1'b0, 0, 0, 1'b1); step();
    drive(1'b1, 1, 0, 1'b0); step();
    drive(1'b0, 0, 2, 1'b0); step();
    check_eq("overpop_count", 128'(count), 128'(0));

    // Steady push 2 / pop 2 across pointer wrap.
    drive(1'b1, 2, 0, 1'b0); step();
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 2, 2, 1'b0);
      step();
    end
    check_eq("steady_count", 128'(count), 128'(2));

    // Randomized traffic, occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), ($urandom_range(0, 31) == 0));
      rst = ($urandom_range(0, 127) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
